prim_clock_gate_ctrl: RTL and testbench
=======================================

Name: prim_clock_gate_ctrl

Overview:
- Multi-channel clock gating controller with idle-based auto-gating, hysteresis and a wake request/acknowledge handshake.
- Each of NUM_CH channels drives one glitch-free, latch-based gated clock derived from clk_i.
- Sits at the top of a subsystem and feeds per-peripheral clocks.
- Software enables, idle hints and wake requests come from the peripherals and the power-control logic.

Parameters:
NUM_CH, 4, number of gated clock channels (>=1)
IDLE_W, 8, width of the idle hysteresis counter and threshold
WAKE_CYCLES, 2, cycles a channel runs after wake-up before it acknowledges (>=1)

Ports:
clk_i  input  1  source clock
rst_ni  input  1  asynchronous active-low reset
test_en_i  input  1  scan/test override; forces every gate open
ch_en_i  input  NUM_CH  per-channel software enable; 0 forces the channel gated
idle_i  input  NUM_CH  per-channel idle hint, synchronous to clk_i
idle_thresh_i  input  IDLE_W  consecutive idle cycles before gating, shared by all channels; 0 disables auto-gating
wake_req_i  input  NUM_CH  per-channel wake request; level, held until acknowledged
wake_ack_o  output  NUM_CH  per-channel wake acknowledge
gated_o  output  NUM_CH  channel is in GATED (registered status)
clk_o  output  NUM_CH  gated clocks

Behaviour:
- One clock and one asynchronous, active-low reset. Clock port: clk_i. Reset port: rst_ni.
- Per channel: a 4-state FSM (RUN, IDLE_CNT, GATED, WAKE), an IDLE_W-bit idle counter, and a WAKE_CYCLES counter.
- Registered enable en_q = 1 in RUN, IDLE_CNT and WAKE; en_q = 0 in GATED.
- Gate: a latch is transparent while clk_i is low and captures en_q | test_en_i. clk_o = latch & clk_i. No combinational path from en_q to clk_o while clk_i is high.
- Reset state:
  - FSM = RUN, counters = 0, en_q = 1, gated_o = 0.
  - clk_o follows clk_i.
  - wake_ack_o = 0 while rst_ni = 0.
- Priority in every state: ch_en_i = 0 -> GATED on the next edge.
- RUN:
  - wake_req_i = 1 -> stay in RUN.
  - Else idle_i = 1 and T = idle_thresh_i:
    - T = 0 -> stay in RUN.
    - T = 1 -> GATED.
    - T > 1 -> IDLE_CNT with cnt = 1.
- IDLE_CNT:
  - idle_i = 0 or wake_req_i = 1 -> RUN, cnt = 0.
  - Else cnt+1 >= T -> GATED.
  - Else cnt = cnt+1.
  - T is re-read every cycle. A T lowered below cnt gates on the next idle cycle. T changed to 0 -> RUN.
- GATED:
  - ch_en_i = 1 and (wake_req_i = 1 or idle_i = 0) -> WAKE, wake counter = 0.
  - Otherwise stay in GATED.
- WAKE:
  - Wake counter increments each cycle.
  - At WAKE_CYCLES-1 -> RUN.
  - Idle is ignored in WAKE.
- gated_o = registered (state == GATED); it updates on the same edge as the FSM.
- wake_ack_o[i] = wake_req_i[i] & rst_ni & (state is RUN or IDLE_CNT). Four-phase handshake: the requester drops req after ack, and ack falls combinationally with req.
- Gating latency: en_q changes at rising edge k. clk_o high phase k (same cycle) is unaffected. The first suppressed or restored pulse is the one following edge k.
- test_en_i = 1: all clk_o follow clk_i. The FSMs, gated_o and wake_ack_o keep operating normally.
- Channels are fully independent.
- Asynchronous reset mid-operation: every FSM immediately goes to RUN. The clock restores from the next clk_i low phase.

Test Plan:
1. Reset release, all ch_en_i = 1, idle_i = 0 -> clk_o = clk_i on all channels; gated_o = 0; wake_ack_o = 0.
2. idle_thresh_i = 3, idle_i[0] high continuously -> gated_o[0] rises on the 3rd idle-sampling edge; clk_o[0] has no pulses after the following edge; channels 1-3 keep toggling.
3. idle_thresh_i = 4, idle_i[1] high for 2 cycles then low for 1, then high for 4 -> no gating after the first burst; gated on the 4th edge of the second burst.
4. Channel 2 GATED, WAKE_CYCLES = 2, wake_req_i[2] raised at edge n -> WAKE at n+1; RUN at n+2; wake_ack_o[2] = 1 after n+2; clk_o[2] pulses from cycle n+1. Then drop req -> ack = 0 in the same cycle; with idle_i = 1 and T = 1, GATED one edge later.
5. Channel in RUN, ch_en_i dropped simultaneously with wake_req_i = 1 -> GATED next edge, no ack; idle_thresh_i = 0 with idle_i = 1 -> never gated.
6. test_en_i = 1 with all channels GATED -> clk_o = clk_i on all channels, gated_o stays 1111; rst_ni pulsed low mid-IDLE_CNT -> FSM to RUN, cnt = 0, gated_o = 0 immediately.

Source files
------------

// File: rtl/prim_clock_gate_ctrl.sv
// Multi-channel clock gating controller.
// Each channel runs a small FSM that gates its clock after a run of idle
// cycles, reopens it on a wake request or activity, and acknowledges wake
// requests once the channel is running again. The clock gate itself is a
// latch that is transparent while clk_i is low, so enable changes never
// shorten a high phase of clk_o.
module prim_clock_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              test_en_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  input  logic [NUM_CH-1:0] idle_i,
  input  logic [IDLE_W-1:0] idle_thresh_i,
  input  logic [NUM_CH-1:0] wake_req_i,
  output logic [NUM_CH-1:0] wake_ack_o,
  output logic [NUM_CH-1:0] gated_o,
  output logic [NUM_CH-1:0] clk_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_IDLE_CNT = 2'd1,
    ST_GATED    = 2'd2,
    ST_WAKE     = 2'd3
  } state_e;

  // The wake counter starts at 0 on entry and the channel returns to RUN on
  // the edge where it reaches WAKE_CYCLES-1, so WAKE lasts WAKE_CYCLES-1
  // cycles (at least one).
  localparam int WAKE_LEN = (WAKE_CYCLES > 1) ? WAKE_CYCLES - 1 : 1;
  localparam int WAKE_W   = (WAKE_LEN > 1) ? $clog2(WAKE_LEN) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_LEN - 1);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_e            state_reg;
    logic [IDLE_W-1:0] idle_cnt_reg;
    logic [WAKE_W-1:0] wake_cnt_reg;
    logic              en_reg;
    logic              gated_reg;
    logic              latch_en;
    logic [IDLE_W:0]   idle_cnt_next;

    // One extra bit so the threshold compare cannot wrap.
    assign idle_cnt_next = {1'b0, idle_cnt_reg} + (IDLE_W + 1)'(1);

    // Per-channel FSM with registered enable and gated status.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_reg    <= ST_RUN;
        idle_cnt_reg <= '0;
        wake_cnt_reg <= '0;
        en_reg       <= 1'b1;
        gated_reg    <= 1'b0;
      end else if (!ch_en_i[gi]) begin
        state_reg    <= ST_GATED;
        idle_cnt_reg <= '0;
        wake_cnt_reg <= '0;
        en_reg       <= 1'b0;
        gated_reg    <= 1'b1;
      end else begin
        case (state_reg)
          ST_RUN: begin
            if (!wake_req_i[gi] && idle_i[gi] && (idle_thresh_i != '0)) begin
              if (idle_thresh_i == IDLE_W'(1)) begin
                state_reg <= ST_GATED;
                en_reg    <= 1'b0;
                gated_reg <= 1'b1;
              end else begin
                state_reg    <= ST_IDLE_CNT;
                idle_cnt_reg <= IDLE_W'(1);
              end
            end
          end
          ST_IDLE_CNT: begin
            // Threshold is re-read every cycle; 0 cancels the countdown.
            if (!idle_i[gi] || wake_req_i[gi] || (idle_thresh_i == '0)) begin
              state_reg    <= ST_RUN;
              idle_cnt_reg <= '0;
            end else if (idle_cnt_next >= {1'b0, idle_thresh_i}) begin
              state_reg    <= ST_GATED;
              idle_cnt_reg <= '0;
              en_reg       <= 1'b0;
              gated_reg    <= 1'b1;
            end else begin
              idle_cnt_reg <= idle_cnt_next[IDLE_W-1:0];
            end
          end
          ST_GATED: begin
            if (wake_req_i[gi] || !idle_i[gi]) begin
              state_reg    <= ST_WAKE;
              wake_cnt_reg <= '0;
              en_reg       <= 1'b1;
              gated_reg    <= 1'b0;
            end
          end
          ST_WAKE: begin
            // Idle hints are ignored until the channel has settled.
            if (wake_cnt_reg == WAKE_LAST) begin
              state_reg    <= ST_RUN;
              wake_cnt_reg <= '0;
            end else begin
              wake_cnt_reg <= wake_cnt_reg + WAKE_W'(1);
            end
          end
          default: begin
            state_reg <= ST_RUN;
            en_reg    <= 1'b1;
            gated_reg <= 1'b0;
          end
        endcase
      end
    end

    // Gate latch: follows the enable only while clk_i is low.
    always_latch begin
      if (!clk_i) begin
        latch_en = en_reg | test_en_i;
      end
    end

    assign clk_o[gi]      = latch_en & clk_i;
    assign gated_o[gi]    = gated_reg;
    assign wake_ack_o[gi] = wake_req_i[gi] & rst_ni &
                            ((state_reg == ST_RUN) || (state_reg == ST_IDLE_CNT));
  end

endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// Bench for prim_clock_gate_ctrl: directed scenarios followed by random
// stimulus, checked through a scoreboard queue against a counter-based model.
module tb_prim_clock_gate_ctrl;
  localparam int NUM_CH      = 4;
  localparam int IDLE_W      = 8;
  localparam int WAKE_CYCLES = 2;
  localparam int WAKE_LEN    = (WAKE_CYCLES > 1) ? WAKE_CYCLES - 1 : 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              test_en = 1'b0;
  logic [NUM_CH-1:0] ch_en = '1;
  logic [NUM_CH-1:0] idle = '0;
  logic [IDLE_W-1:0] thresh = '0;
  logic [NUM_CH-1:0] wake_req = '0;
  logic [NUM_CH-1:0] wake_ack;
  logic [NUM_CH-1:0] gated;
  logic [NUM_CH-1:0] clk_g;

  prim_clock_gate_ctrl #(
    .NUM_CH(NUM_CH), .IDLE_W(IDLE_W), .WAKE_CYCLES(WAKE_CYCLES)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en), .ch_en_i(ch_en),
    .idle_i(idle), .idle_thresh_i(thresh), .wake_req_i(wake_req),
    .wake_ack_o(wake_ack), .gated_o(gated), .clk_o(clk_g)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] gated;
    logic [NUM_CH-1:0] ack;
    logic [NUM_CH-1:0] clk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;

  // Model: a channel is either gated, or waking (cycles left), or running
  // with a count of consecutive idle cycles.
  bit m_gated[NUM_CH];
  int m_streak[NUM_CH];
  int m_wake_left[NUM_CH];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_gated[c] = 0; m_streak[c] = 0; m_wake_left[c] = 0;
    end
  endtask

  // Compute the response to the inputs now applied and queue it.
  task automatic push_expect();
    exp_t e;
    int t;
    e = '0;
    t = int'(thresh);
    for (int c = 0; c < NUM_CH; c++) begin
      e.clk[c] = !m_gated[c] || test_en;
      if (rst_n) begin
        if (!ch_en[c]) begin
          m_gated[c] = 1; m_streak[c] = 0; m_wake_left[c] = 0;
        end else if (m_gated[c]) begin
          if (wake_req[c] || !idle[c]) begin
            m_gated[c] = 0; m_wake_left[c] = WAKE_LEN;
          end
        end else if (m_wake_left[c] > 0) begin
          m_wake_left[c]--;
        end else if (wake_req[c] || !idle[c] || t == 0) begin
          m_streak[c] = 0;
        end else begin
          m_streak[c]++;
          if (m_streak[c] >= t) begin
            m_gated[c] = 1; m_streak[c] = 0;
          end
        end
      end
      e.gated[c] = m_gated[c];
      e.ack[c]   = wake_req[c] && rst_n && !m_gated[c] && (m_wake_left[c] == 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] idl,
                       input logic [NUM_CH-1:0] req, input int t, input bit te,
                       input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ch_en = en; idle = idl; wake_req = req; thresh = IDLE_W'(t); test_en = te;
      push_expect();
    end
  endtask

  // Asynchronous reset pulse in the middle of a low phase.
  task automatic mid_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (gated !== '0 || wake_ack !== '0) begin
      n_fail++;
      $display("FAIL async_reset cycle %0d: gated_o=%b wake_ack_o=%b, required 0000/0000",
               cycle, gated, wake_ack);
    end
    push_expect();
    @(negedge clk);
    rst_n = 1'b1;
    push_expect();
  endtask

  // Monitor: compare against the queued expectation after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cycle++;
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (gated !== e.gated) begin
          n_fail++;
          $display("FAIL gated cycle %0d: got %b, required %b", cycle, gated, e.gated);
        end
        n_checks++;
        if (wake_ack !== e.ack) begin
          n_fail++;
          $display("FAIL wake_ack cycle %0d: got %b, required %b", cycle, wake_ack, e.ack);
        end
        n_checks++;
        if (clk_g !== e.clk) begin
          n_fail++;
          $display("FAIL clk_high cycle %0d: got %b, required %b", cycle, clk_g, e.clk);
        end
        $display("cycle %0d: gated=%b ack=%b clk_hi=%b", cycle, gated, wake_ack, clk_g);
      end
    end
  end

  // Gated clocks must be low whenever the source clock is low.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      n_checks++;
      if (clk_g !== '0) begin
        n_fail++;
        $display("FAIL clk_low cycle %0d: got %b, required 0000", cycle, clk_g);
      end
    end
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_expect();
    // reset release, everything running
    drive(4'hF, 4'h0, 4'h0, 0, 0, 3);
    // channel 0 idle with threshold 3
    drive(4'hF, 4'b0001, 4'h0, 3, 0, 5);
    // channel 1: short burst, break, long burst with threshold 4
    drive(4'hF, 4'b0011, 4'h0, 4, 0, 2);
    drive(4'hF, 4'b0001, 4'h0, 4, 0, 1);
    drive(4'hF, 4'b0011, 4'h0, 4, 0, 5);
    // channel 2: gate with threshold 1, wake, then re-gate
    drive(4'hF, 4'b0111, 4'h0, 1, 0, 2);
    drive(4'hF, 4'b0111, 4'b0100, 1, 0, 3);
    drive(4'hF, 4'b0111, 4'h0, 1, 0, 3);
    // channel 3 disabled while requesting wake; threshold 0 never gates
    drive(4'b0111, 4'h0, 4'b1000, 0, 0, 2);
    drive(4'hF, 4'hF, 4'h0, 0, 0, 6);
    // all gated under test enable, then wake, count idle, reset mid-count
    drive(4'h0, 4'hF, 4'h0, 0, 1, 3);
    drive(4'hF, 4'h0, 4'h0, 10, 0, 3);
    drive(4'hF, 4'hF, 4'h0, 10, 0, 3);
    mid_reset();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 75) begin
        mid_reset();
      end else begin
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
          ch_en[c]    = ($urandom % 10) != 0;
          idle[c]     = ($urandom % 4) != 0;
          wake_req[c] = ($urandom % 6) == 0;
        end
        thresh  = IDLE_W'($urandom_range(0, 5));
        test_en = ($urandom % 8) == 0;
        push_expect();
      end
    end
    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
